// File: rtl/bcd_up_counter_cascade_if.sv
// bcd_up_counter_cascade_if: control and status bundle for the cascadable BCD up counter
interface bcd_up_counter_cascade_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  cin;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   q;
  logic                  cout;
  logic                  load_err;
  logic                  ovf;
  modport master (output en, cin, load, load_val, input q, cout, load_err, ovf);
  modport slave  (input en, cin, load, load_val, output q, cout, load_err, ovf);
endinterface

// File: rtl/bcd_up_counter_cascade.sv
// bcd_up_counter_cascade: multi-digit BCD up counter with load, carry chain and sticky overflow (option BCD_CNT_SATURATE_EN)
module bcd_up_counter_cascade #(
  parameter int DIGITS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  bcd_up_counter_cascade_if.slave  bus
);
  localparam int W = 4 * DIGITS;
`ifdef BCD_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic [W-1:0]      q_q, q_d, inc_d, ld_d;
  logic              ovf_q, ovf_d, load_err_q, load_err_d;
  logic [DIGITS:0]   c;
  logic [DIGITS-1:0] bad;
  logic              step, all9;
  assign c[0] = 1'b1;
  // c[g] is high when every lower digit is at 9; digits above 9 are treated as 9 so they roll to 0
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [3:0] d, v;
    assign d                = q_q[4*g +: 4];
    assign v                = bus.load_val[4*g +: 4];
    assign c[g+1]           = c[g] & (d >= 4'd9);
    assign inc_d[4*g +: 4]  = c[g] ? ((d >= 4'd9) ? 4'd0 : d + 4'd1) : d;
    assign bad[g]           = v > 4'd9;
    assign ld_d[4*g +: 4]   = bad[g] ? 4'd0 : v;
  end
  assign all9 = c[DIGITS];
  assign step = bus.en & bus.cin & ~bus.load;
  // priority load > count > hold; a saturating build freezes at all-9s instead of wrapping
  always_comb begin
    q_d        = bus.load ? ld_d : (step & ~(SAT & all9)) ? inc_d : q_q;
    ovf_d      = bus.load ? 1'b0 : ovf_q | (step & all9);
    load_err_d = bus.load & |bad;
  end
  // state registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q        <= '0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end
  assign bus.q        = q_q;
  assign bus.ovf      = ovf_q;
  assign bus.load_err = load_err_q;
  assign bus.cout     = ~SAT & step & all9;
endmodule
